// File: rtl/memory_dumper_pkg.sv
// Shared constants and FSM encoding for the memory dump engine.
package memory_dumper_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/memory_dumper.sv
// Streams a contiguous (wrapping) range of data_memory words to a ready/valid sink.
module memory_dumper
  import memory_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  dump_state_t           state, state_nxt;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  start_ok;
  logic                  xfer;

  assign start_ok = start && (length != '0);
  assign xfer     = (state == SEND) && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (length != '0) ? FETCH : DONE;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (out_ready) state_nxt = (remaining > REM_ONE) ? FETCH : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/out_valid/done decode straight from state so reset clears them immediately.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      FETCH, CAPTURE: busy = 1'b1;
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_address <= '0;
      out_data    <= '0;
      remaining   <= '0;
    end else begin
      if (state == IDLE && start_ok) begin
        mem_address <= base_addr;
        remaining   <= length;
      end
      if (state == CAPTURE) out_data <= mem_data;
      if (xfer) begin
        remaining <= remaining - REM_ONE;
        // Address stays on the last word when the dump ends.
        if (remaining > REM_ONE) mem_address <= mem_address + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_dumper.sv
// Scoreboard bench for memory_dumper with a synchronous-read memory model.
module tb_memory_dumper;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned busy_cnt, done_cnt, valid_cnt, words_seen;
  logic        held_valid = 1'b0;
  logic [7:0]  held_data;
  logic [7:0]  addr0;

  memory_dumper #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_data <= mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      held_valid = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_valid) valid_cnt++;
      if (held_valid) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_word", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("addr", 32'(mem_address), 32'(e.a));
          chk("data", 32'(out_data), 32'(e.d));
        end
        words_seen++;
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; valid_cnt = 0; words_seen = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n, input bit push);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; length = n;
    if (push)
      for (int unsigned i = 0; i < n; i++) begin
        logic [7:0] a;
        a = b + 8'(i);
        sb.push_back({a, mem[a]});
      end
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned max_cycles);
    int unsigned k = 0;
    while (!done && k < max_cycles) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
    mem[8'hFE] = 8'h5E; mem[8'hFF] = 8'h6F; mem[8'h00] = 8'h70; mem[8'h01] = 8'h81;

    reset = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    reset = 1'b1;

    // Basic dump, full throughput
    clear_counts();
    do_start(8'h10, 9'd4, 1'b1);
    wait_done("t1", 40);
    chk("t1_busy_cycles", busy_cnt, 32'd12);
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_words", words_seen, 32'd4);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Address wrap
    clear_counts();
    do_start(8'hFE, 9'd4, 1'b1);
    wait_done("t2", 40);
    chk("t2_words", words_seen, 32'd4);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure on first word
    clear_counts();
    out_ready = 1'b0;
    do_start(8'h30, 9'd2, 1'b1);
    for (int unsigned k = 0; k < 20 && !out_valid; k++) @(negedge clock);
    chk("t3_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clock);
    #1 out_ready = 1'b1;
    wait_done("t3", 40);
    chk("t3_words", words_seen, 32'd2);
    chk("t3_done_cnt", done_cnt, 32'd1);

    // Zero length
    clear_counts();
    addr0 = mem_address;
    do_start(8'h55, 9'd0, 1'b0);
    chk("t4_done_now", 32'(done), 32'd1);
    @(posedge clock); #1;
    chk("t4_done_gone", 32'(done), 32'd0);
    chk("t4_valid_cnt", valid_cnt, 32'd0);
    chk("t4_addr", 32'(mem_address), 32'(addr0));
    chk("t4_done_cnt", done_cnt, 32'd1);

    // Reset abort during second word, then fresh dump
    clear_counts();
    do_start(8'h20, 9'd8, 1'b1);
    for (int unsigned k = 0; k < 40 && words_seen < 1; k++) @(negedge clock);
    chk("t5_first_word", words_seen, 32'd1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("t5_addr", 32'(mem_address), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_data", 32'(out_data), 32'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    repeat (3) @(posedge clock);
    chk("t5_no_done", done_cnt, 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    clear_counts();
    do_start(8'h00, 9'd1, 1'b1);
    wait_done("t5b", 20);
    chk("t5b_words", words_seen, 32'd1);

    // Start while busy ignored
    clear_counts();
    do_start(8'h40, 9'd3, 1'b1);
    do_start(8'h80, 9'd5, 1'b0);
    wait_done("t6", 40);
    repeat (4) @(posedge clock);
    chk("t6_words", words_seen, 32'd3);
    chk("t6_done_cnt", done_cnt, 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
